// File: rtl/md_pkg.sv
// Shared encodings and constants for the EXE-stage multiply/divide unit.
package md_pkg;
  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MUL_LAT_DEF = 4;

  // Divide-by-zero result: quotient all ones, remainder = dividend
  localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_e;
endpackage

// File: rtl/exe_muldiv_if.sv
// Handshake between the ID/EXE register and the mult/div unit.
interface exe_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_req;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_val, rt_val, rd_req, flush,
                  input  busy, stall_req, done, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, rd_req, flush,
                  output busy, stall_req, done, hi, lo);
endinterface

// File: rtl/md_div_core.sv
// Unsigned restoring divider datapath: one shift-subtract step per enabled cycle.
module md_div_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dvd_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q;
  logic [32:0] sh;
  logic [33:0] diff;
  logic        unused_bits;

  always_comb begin
    sh    = {rem_q, quo_q[31]};
    diff  = {1'b0, sh} - {2'b00, dvs_q};
    rem_d = rem_q;
    quo_d = quo_q;
    if (step_i) begin
      // No borrow means the shifted remainder covers the divisor
      if (!diff[33]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = sh[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  assign unused_bits = ^{diff[32], sh[32]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dvd_i;
      dvs_q <= dvs_i;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;
endmodule

// File: rtl/exe_muldiv.sv
// EXE-stage iterative multiply/divide unit owning the architectural HI/LO registers.
module exe_muldiv
  import md_pkg::*;
#(
  parameter int MUL_LAT   = MUL_LAT_DEF,
  parameter int DIV_ITERS = 32
) (
  input logic          clk,
  input logic          rst,
  exe_muldiv_if.slave  md
);
  localparam int CMAX = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
  localparam int CW   = $clog2(CMAX + 1);

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, lo_q, rs_q;
  logic        busy_q, done_q, qneg_q, rneg_q, dvz_q;
  logic [31:0] dvd_d, dvs_d, quo, rem, quo_fix, rem_fix;
  logic        is_sdiv, acc, div_load;

  always_comb begin
    if (md.op == MD_MULT)
      prod_d = $signed({{32{md.rs_val[31]}}, md.rs_val}) *
               $signed({{32{md.rt_val[31]}}, md.rt_val});
    else
      prod_d = {32'd0, md.rs_val} * {32'd0, md.rt_val};
    is_sdiv = (md.op == MD_DIV);
    dvd_d   = (is_sdiv && md.rs_val[31]) ? -md.rs_val : md.rs_val;
    dvs_d   = (is_sdiv && md.rt_val[31]) ? -md.rt_val : md.rt_val;
    quo_fix = qneg_q ? -quo : quo;
    rem_fix = rneg_q ? -rem : rem;
  end

  assign acc      = (state_q == ST_IDLE) && md.start && !md.flush;
  assign div_load = acc && (md.op == MD_DIV || md.op == MD_DIVU);

  md_div_core u_div (
    .clk    (clk),
    .rst    (rst),
    .load_i (div_load),
    .step_i ((state_q == ST_DIV) && !md.flush),
    .dvd_i  (dvd_d),
    .dvs_i  (dvs_d),
    .quo_o  (quo),
    .rem_o  (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rs_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (acc) begin
          case (md.op)
            MD_MULT, MD_MULTU: begin
              prod_q  <= prod_d;
              cnt_q   <= CW'(MUL_LAT);
              busy_q  <= 1'b1;
              state_q <= ST_MUL;
            end
            MD_DIV, MD_DIVU: begin
              qneg_q  <= is_sdiv & (md.rs_val[31] ^ md.rt_val[31]);
              rneg_q  <= is_sdiv & md.rs_val[31];
              dvz_q   <= (md.rt_val == 32'd0);
              rs_q    <= md.rs_val;
              cnt_q   <= CW'(DIV_ITERS);
              busy_q  <= 1'b1;
              state_q <= ST_DIV;
            end
            MD_MTHI: hi_q <= md.rs_val;
            MD_MTLO: lo_q <= md.rs_val;
            default: ;
          endcase
        end
        ST_MUL: begin
          if (md.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(1)) begin
            {hi_q, lo_q} <= prod_q;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DIV: begin
          if (md.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(1)) begin
            state_q <= ST_FIX;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!md.flush) begin
            // Zero divisor bypasses the sign fixup entirely
            lo_q   <= dvz_q ? DIVZ_LO : quo_fix;
            hi_q   <= dvz_q ? rs_q : rem_fix;
            done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md.busy      = busy_q;
  assign md.done      = done_q;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.stall_req = busy_q & (md.start | md.rd_req);
endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv with a done-driven HI/LO scoreboard.
module tb_exe_muldiv;
  import md_pkg::*;
  localparam int MUL_LAT   = 4;
  localparam int DIV_ITERS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_muldiv_if ifc ();
  exe_muldiv #(.MUL_LAT(MUL_LAT), .DIV_ITERS(DIV_ITERS)) dut (
    .clk (clk),
    .rst (rst),
    .md  (ifc)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] expq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected {hi,lo}
  always @(negedge clk) begin
    if (!rst && ifc.done) begin
      if (expq.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("hilo", {ifc.hi, ifc.lo}, expq.pop_front());
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    ifc.start = 1'b1; ifc.op = op; ifc.rs_val = rs; ifc.rt_val = rt;
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.op = MD_NOP;
  endtask

  task automatic wait_done(output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ifc.done) got = 1;
      else if (ifc.busy) lat++;
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [63:0] exp, input int explat);
    int lat;
    expq.push_back(exp);
    drive(op, rs, rt);
    wait_done(lat);
    check({name, "_lat"}, 64'(lat), 64'(explat));
    @(negedge clk);
    check({name, "_pulse"}, {63'd0, ifc.done}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, dn;
    ifc.start = 0; ifc.op = MD_NOP; ifc.rs_val = 0; ifc.rt_val = 0;
    ifc.rd_req = 0; ifc.flush = 0;
    #3;
    check("rst_hilo", {ifc.hi, ifc.lo}, 64'd0);
    check("rst_busy", {63'd0, ifc.busy}, 64'd0);
    check("rst_done", {63'd0, ifc.done}, 64'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    run("mult",  MD_MULT,  32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, MUL_LAT);
    run("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, MUL_LAT);
    run("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_ITERS + 1);
    run("divu",  MD_DIVU,  32'd100,       32'd7, {32'd2, 32'd14}, DIV_ITERS + 1);
    run("div0",  MD_DIV,   32'd5,         32'd0, {32'd5, 32'hFFFF_FFFF}, DIV_ITERS + 1);
    run("divu0", MD_DIVU,  32'hDEAD_0001, 32'd0, {32'hDEAD_0001, 32'hFFFF_FFFF}, DIV_ITERS + 1);
    run("ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_ITERS + 1);

    // Stall: reader and a MULT arrive mid-divide; MULT is held until IDLE
    expq.push_back({32'd1, 32'd4});
    expq.push_back({32'd0, 32'd15});
    drive(MD_DIV, 32'd9, 32'd2);
    repeat (3) @(posedge clk); #1;
    ifc.start = 1'b1; ifc.op = MD_MULT; ifc.rs_val = 32'd3; ifc.rt_val = 32'd5; ifc.rd_req = 1'b1;
    @(negedge clk);
    check("stall_req", {63'd0, ifc.stall_req}, 64'd1);
    check("stall_hold", {ifc.hi, ifc.lo}, {32'd0, 32'h8000_0000});
    wait_done(lat);
    check("stall_clear", {63'd0, ifc.stall_req}, 64'd0);
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.op = MD_NOP; ifc.rd_req = 1'b0;
    wait_done(lat);
    check("held_mult_lat", 64'(lat), 64'(MUL_LAT));
    @(posedge clk); #1;

    // Flush on the 10th divide cycle
    drive(MD_DIV, 32'd50, 32'd3);
    repeat (9) @(posedge clk); #1;
    ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    check("flush_busy", {63'd0, ifc.busy}, 64'd0);
    dn = 0;
    repeat (40) begin @(negedge clk); if (ifc.done) dn++; end
    check("flush_nodone", 64'(dn), 64'd0);
    check("flush_hilo", {ifc.hi, ifc.lo}, {32'd0, 32'd15});
    @(posedge clk); #1;

    // MTLO/MTHI, with and without flush
    ifc.start = 1'b1; ifc.op = MD_MTLO; ifc.rs_val = 32'h1234; ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.op = MD_NOP; ifc.flush = 1'b0;
    check("mtlo_flush", 64'(ifc.lo), 64'd15);
    drive(MD_MTLO, 32'h1234, 32'd0);
    check("mtlo", 64'(ifc.lo), 64'h1234);
    drive(MD_MTHI, 32'hABCD, 32'd0);
    check("mthi", 64'(ifc.hi), 64'hABCD);
    check("mt_nobusy", {63'd0, ifc.busy}, 64'd0);

    // Asynchronous reset in the middle of a multiply
    drive(MD_MULT, 32'd6, 32'd7);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_hilo", {ifc.hi, ifc.lo}, 64'd0);
    check("arst_busy", {63'd0, ifc.busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (10) begin @(negedge clk); if (ifc.done) dn++; end
    check("arst_nodone", 64'(dn), 64'd0);

    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
